sram_like_responder: RTL and testbench

Slave-side responder for the CPU's sram-like memory interface: accepts one request at a time, runs it against a local word-addressed memory, and returns `data_ok` after a fixed, parameterised delay. It sits opposite the CPU's instruction or data fetch port. It is used as the memory model in CPU simulation and as on-chip scratch memory in small builds. Request/response pacing is deterministic, so pipeline stall logic can be exercised cycle-exactly.

---
 rtl/sram_like_responder.sv | 132 +++++++++++++
 tb/tb_sram_like_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// rtl/sram_like_responder.sv - sram-like slave responder with fixed response latency
// One transaction in flight; local word memory with byte-lane writes.
module sram_like_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int AW = DEPTH_LOG2 + 2;
   localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state, state_nx;
   logic [3:0]        cnt, cnt_nx;
   logic              c_wr;
   logic [1:0]        c_size;
   logic [AW-1:0]     c_addr;
   logic [31:0]       c_wdata;
   logic [31:0]       mem [0:(1<<DEPTH_LOG2)-1];

   logic              accept;
   logic              enter_resp;
   logic              e_wr;
   logic [1:0]        e_size;
   logic [AW-1:0]     e_addr;
   logic [31:0]       e_wdata;
   logic [3:0]        be;
   logic              legal;
   logic [DEPTH_LOG2-1:0] idx;
   logic              unused_ok;

   assign addr_ok = (state == IDLE) && !rst;
   assign data_ok = (state == RESP) && !rst;
   assign accept  = req && addr_ok;
   assign unused_ok = ^addr[31:AW];

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_nx = RESP;
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_nx = RESP;
            else             cnt_nx   = cnt - 4'd1;
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // With LATENCY=1 the commit edge is the accept edge, so use the live inputs there.
   assign enter_resp = (state_nx == RESP) && (state != RESP) && !rst;
   assign e_wr    = (state == IDLE) ? wr         : c_wr;
   assign e_size  = (state == IDLE) ? size       : c_size;
   assign e_addr  = (state == IDLE) ? addr[AW-1:0] : c_addr;
   assign e_wdata = (state == IDLE) ? wdata      : c_wdata;
   assign idx     = e_addr[AW-1:2];

   always_comb begin
      be    = 4'b0000;
      legal = 1'b0;
      case (e_size)
         2'd0: begin
            be    = 4'b0001 << e_addr[1:0];
            legal = 1'b1;
         end
         2'd1: begin
            be    = 4'b0011 << e_addr[1:0];
            legal = !e_addr[0];
         end
         2'd2: begin
            be    = 4'b1111;
            legal = (e_addr[1:0] == 2'b00);
         end
         default: begin
            be    = 4'b0000;
            legal = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         c_wr    <= 1'b0;
         c_size  <= 2'd0;
         c_addr  <= '0;
         c_wdata <= 32'd0;
         rdata   <= 32'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            c_wr    <= wr;
            c_size  <= size;
            c_addr  <= addr[AW-1:0];
            c_wdata <= wdata;
         end
         if (enter_resp && !e_wr) rdata <= mem[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (enter_resp && e_wr && legal) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= e_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_sram_like_responder.sv
// tb/tb_sram_like_responder.sv - scoreboard bench for sram_like_responder
// Four instances: LATENCY 2, 1, 3 (depth 1024) and LATENCY 2 with depth 16.
module tb_sram_like_responder;

   logic        clk = 1'b0;
   logic        rst_s     [4];
   logic        req_s     [4];
   logic        wr_s      [4];
   logic [1:0]  size_s    [4];
   logic [31:0] addr_s    [4];
   logic [31:0] wdata_s   [4];
   logic        addr_ok_s [4];
   logic        data_ok_s [4];
   logic [31:0] rdata_s   [4];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int          cyc;
      logic [31:0] rd;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int LAT = (g == 1) ? 1 : (g == 2) ? 3 : 2;
      localparam int DL  = (g == 3) ? 4 : 10;
      sram_like_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) u_dut (
         .clk     (clk),
         .rst     (rst_s[g]),
         .req     (req_s[g]),
         .wr      (wr_s[g]),
         .size    (size_s[g]),
         .addr    (addr_s[g]),
         .wdata   (wdata_s[g]),
         .addr_ok (addr_ok_s[g]),
         .data_ok (data_ok_s[g]),
         .rdata   (rdata_s[g])
      );
   end

   function automatic int lat_of(input int g);
      return (g == 1) ? 1 : (g == 2) ? 3 : 2;
   endfunction

   // Drive one request from a negedge; returns at the negedge after the accept edge.
   task automatic issue(input int g, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
      bit ok;
      exp_t e;
      ok = 0;
      @(negedge clk);
      req_s[g] = 1'b1; wr_s[g] = w; size_s[g] = sz; addr_s[g] = a; wdata_s[g] = d;
      for (int i = 0; i < 20; i++) begin
         if (addr_ok_s[g]) begin ok = 1; break; end
         @(negedge clk);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL issue_accept inst %0d: addr_ok never seen, required 1", g);
      end else begin
         @(negedge clk);
         e.cyc = cyc + lat_of(g) - 1;
         e.rd  = exp_rd;
         sbq.push_back(e);
      end
      req_s[g] = 1'b0; addr_s[g] = 32'hFFFF_FFFC; wdata_s[g] = 32'h0BAD_0BAD;
   endtask

   task automatic collect(input int g, output bit got, output int c, output logic [31:0] rd);
      got = 0; c = -1; rd = 32'hx;
      for (int i = 0; i < 20; i++) begin
         if (data_ok_s[g]) begin got = 1; c = cyc; rd = rdata_s[g]; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      for (int g = 0; g < 4; g++) begin
         rst_s[g] = 1'b1; req_s[g] = 1'b0; wr_s[g] = 1'b0;
         size_s[g] = 2'd0; addr_s[g] = 32'd0; wdata_s[g] = 32'd0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
         checks++;
         if (addr_ok_s[g] !== 1'b0 || data_ok_s[g] !== 1'b0 || rdata_s[g] !== 32'd0) begin
            errors++;
            $display("FAIL reset_vals inst %0d: addr_ok %b data_ok %b rdata %h, required 0 0 00000000",
                     g, addr_ok_s[g], data_ok_s[g], rdata_s[g]);
         end
      end
      for (int g = 0; g < 4; g++) rst_s[g] = 1'b0;
      #1;
      for (int g = 0; g < 4; g++) begin
         checks++;
         if (addr_ok_s[g] !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_addr_ok inst %0d: got %b, required 1", g, addr_ok_s[g]);
         end
      end
   endtask

   // Scenario table runner body is repeated per test so each keeps its own checks.
   task automatic test_basic;
      logic        w  [2] = '{1'b1, 1'b0};
      logic [31:0] d  [2] = '{32'hDEADBEEF, 32'h0};
      logic [31:0] er [2] = '{32'h0, 32'hDEADBEEF};
      bit got; int c; logic [31:0] rd; exp_t e;
      for (int i = 0; i < 2; i++) begin
         issue(0, w[i], 2'd2, 32'h100, d[i], er[i]);
         collect(0, got, c, rd);
         e = sbq.pop_front();
         checks++;
         if (!got || c !== e.cyc || rd !== e.rd) begin
            errors++;
            $display("FAIL basic[%0d]: data_ok %0d cyc %0d rdata %h, required 1 cyc %0d rdata %h",
                     i, got, c, rd, e.cyc, e.rd);
         end
      end
   endtask

   task automatic test_merge;
      logic        w  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [1:0]  sz [7] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3};
      logic [31:0] a  [7] = '{32'h40, 32'h41, 32'h42, 32'h40, 32'h43, 32'h43, 32'h40};
      logic [31:0] d  [7] = '{32'h11223344, 32'h0000AA00, 32'hBBBB0000, 32'h0,
                              32'hFFFF0000, 32'h0, 32'hFFFFFFFF};
      logic [31:0] er [7] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hBBBBAA44,
                              32'hBBBBAA44, 32'hBBBBAA44, 32'hBBBBAA44};
      bit got; int c; logic [31:0] rd; exp_t e;
      for (int i = 0; i < 7; i++) begin
         issue(0, w[i], sz[i], a[i], d[i], er[i]);
         collect(0, got, c, rd);
         e = sbq.pop_front();
         checks++;
         if (!got || c !== e.cyc || rd !== e.rd) begin
            errors++;
            $display("FAIL merge[%0d]: data_ok %0d cyc %0d rdata %h, required 1 cyc %0d rdata %h",
                     i, got, c, rd, e.cyc, e.rd);
         end
      end
      issue(0, 1'b0, 2'd0, 32'h40, 32'h0, 32'hBBBBAA44);
      collect(0, got, c, rd);
      e = sbq.pop_front();
      checks++;
      if (!got || c !== e.cyc || rd !== e.rd) begin
         errors++;
         $display("FAIL illegal_size3_read: data_ok %0d cyc %0d rdata %h, required 1 cyc %0d rdata %h",
                  got, c, rd, e.cyc, e.rd);
      end
   endtask

   task automatic test_back_to_back;
      bit got; int c; logic [31:0] rd; exp_t e;
      @(negedge clk);
      req_s[1] = 1'b1; wr_s[1] = 1'b1; size_s[1] = 2'd2; addr_s[1] = 32'h10;
      for (int k = 0; k < 8; k++) begin
         wdata_s[1] = 32'(k) + 32'hA000;
         checks++;
         if (addr_ok_s[1] !== ((k % 2) == 0) || data_ok_s[1] !== ((k % 2) == 1)) begin
            errors++;
            $display("FAIL b2b[%0d]: addr_ok %b data_ok %b, required %b %b",
                     k, addr_ok_s[1], data_ok_s[1], (k % 2) == 0, (k % 2) == 1);
         end
         @(negedge clk);
      end
      req_s[1] = 1'b0;
      issue(1, 1'b0, 2'd2, 32'h10, 32'h0, 32'hA006);
      collect(1, got, c, rd);
      e = sbq.pop_front();
      checks++;
      if (!got || c !== e.cyc || rd !== e.rd) begin
         errors++;
         $display("FAIL b2b_readback: data_ok %0d cyc %0d rdata %h, required 1 cyc %0d rdata %h",
                  got, c, rd, e.cyc, e.rd);
      end
   endtask

   task automatic test_reset_mid;
      logic        w  [2] = '{1'b1, 1'b0};
      logic [31:0] d  [2] = '{32'hCAFEF00D, 32'h0};
      logic [31:0] er [2] = '{32'h0, 32'hCAFEF00D};
      bit got; int c; logic [31:0] rd; exp_t e;
      bit seen;
      for (int i = 0; i < 2; i++) begin
         issue(2, w[i], 2'd2, 32'h80, d[i], er[i]);
         collect(2, got, c, rd);
         e = sbq.pop_front();
         checks++;
         if (!got || c !== e.cyc || rd !== e.rd) begin
            errors++;
            $display("FAIL preload[%0d]: data_ok %0d cyc %0d rdata %h, required 1 cyc %0d rdata %h",
                     i, got, c, rd, e.cyc, e.rd);
         end
      end
      issue(2, 1'b1, 2'd2, 32'h80, 32'h12345678, 32'h0);
      sbq.delete();
      rst_s[2] = 1'b1;
      @(negedge clk);
      rst_s[2] = 1'b0;
      checks++;
      if (rdata_s[2] !== 32'd0) begin
         errors++;
         $display("FAIL midreset_rdata: got %h, required 00000000", rdata_s[2]);
      end
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         if (data_ok_s[2]) seen = 1;
         @(negedge clk);
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL midreset_no_data_ok: data_ok seen 1, required 0");
      end
      issue(2, 1'b0, 2'd2, 32'h80, 32'h0, 32'hCAFEF00D);
      collect(2, got, c, rd);
      e = sbq.pop_front();
      checks++;
      if (!got || c !== e.cyc || rd !== e.rd) begin
         errors++;
         $display("FAIL midreset_readback: data_ok %0d cyc %0d rdata %h, required 1 cyc %0d rdata %h",
                  got, c, rd, e.cyc, e.rd);
      end
   endtask

   task automatic test_alias;
      logic        w  [2] = '{1'b1, 1'b0};
      logic [31:0] a  [2] = '{32'h00, 32'h40};
      logic [31:0] d  [2] = '{32'h55, 32'h0};
      logic [31:0] er [2] = '{32'h0, 32'h55};
      bit got; int c; logic [31:0] rd; exp_t e;
      for (int i = 0; i < 2; i++) begin
         issue(3, w[i], 2'd2, a[i], d[i], er[i]);
         collect(3, got, c, rd);
         e = sbq.pop_front();
         checks++;
         if (!got || c !== e.cyc || rd !== e.rd) begin
            errors++;
            $display("FAIL alias[%0d]: data_ok %0d cyc %0d rdata %h, required 1 cyc %0d rdata %h",
                     i, got, c, rd, e.cyc, e.rd);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_merge;
      test_back_to_back;
      test_reset_mid;
      test_alias;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
